// File: rtl/grid_pkg.sv
// Shared encodings for the grid game: cell codes, game phases, fire results,
// and the select-bus width helper used by the controller, color decoder and display.
package grid_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_SHIP  = 2'd1,
      CELL_HIT   = 2'd2,
      CELL_MISS  = 2'd3
   } cell_e;

   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_PLAY  = 2'd1,
      PH_DONE  = 2'd2
   } phase_e;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_MISS   = 2'd1,
      RES_HIT    = 2'd2,
      RES_REPEAT = 2'd3
   } result_e;

   // The switch bus must be wide enough to address the longer board dimension.
   function automatic int sel_w(input int rows, input int cols);
      return (rows > cols) ? rows : cols;
   endfunction

endpackage

// File: rtl/onehot_index.sv
// Converts a one-hot switch vector into a binary index. The error flag is raised
// when zero or more than one switch is set; range checks belong to the caller.
module onehot_index #(
   parameter int W = 4
) (
   input  logic [W-1:0] sw,
   output logic [3:0]   idx,
   output logic         err
);

   int unsigned ones;

   // Count the set switches and remember the position of the set one.
   always_comb begin
      ones = 0;
      idx  = 4'd0;
      for (int i = 0; i < W; i++) begin
         if (sw[i]) begin
            ones = ones + 1;
            idx  = 4'(i);
         end
      end
      err = (ones != 1);
   end

endmodule

// File: rtl/grid_board_ctrl.sv
// Board controller for a small battleship-style game: holds the cell array,
// cursor and game phase, and applies place/fire/start commands one cycle after sampling.
module grid_board_ctrl import grid_pkg::*; #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int MAX_SHIPS = 4,
   localparam int SEL_W    = sel_w(ROWS, COLS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SEL_W-1:0]       sw,
   input  logic                   sw_is_col,
   input  logic                   sw_load,
   input  logic                   place,
   input  logic                   fire,
   input  logic                   start,
   input  logic                   reveal,
   output logic [2*ROWS*COLS-1:0] cell_state,
   output logic [3:0]             cur_row,
   output logic [3:0]             cur_col,
   output logic [1:0]             phase,
   output logic [4:0]             ships_left,
   output logic [7:0]             shots,
   output logic [1:0]             last_result,
   output logic                   sel_err,
   output logic                   game_over
);

   localparam int CELLS = ROWS * COLS;

   logic [2*CELLS-1:0] cells_q, cells_d;
   logic [3:0]         cur_row_q, cur_row_d;
   logic [3:0]         cur_col_q, cur_col_d;
   phase_e             phase_q, phase_d;
   logic [4:0]         ships_left_q, ships_left_d;
   logic [7:0]         shots_q, shots_d;
   result_e            result_q, result_d;
   logic               sel_err_q, sel_err_d;
   logic               game_over_q, game_over_d;

   logic [3:0]         oh_idx;
   logic               oh_err;
   int unsigned        cur_idx;
   cell_e              cur_cell;

   onehot_index #(.W(SEL_W)) u_onehot (
      .sw  (sw),
      .idx (oh_idx),
      .err (oh_err)
   );

   // Next-state logic: cursor loads, then the phase-legal command acting on the old cursor.
   always_comb begin
      cells_d      = cells_q;
      cur_row_d    = cur_row_q;
      cur_col_d    = cur_col_q;
      phase_d      = phase_q;
      ships_left_d = ships_left_q;
      shots_d      = shots_q;
      result_d     = result_q;
      sel_err_d    = sel_err_q;
      cur_idx      = int'(cur_row_q) * COLS + int'(cur_col_q);
      cur_cell     = cell_e'(cells_q[2*cur_idx +: 2]);

      if (sw_load) begin
         if (oh_err || (int'(oh_idx) >= (sw_is_col ? COLS : ROWS))) begin
            sel_err_d = 1'b1;
         end else begin
            sel_err_d = 1'b0;
            if (sw_is_col) cur_col_d = oh_idx;
            else           cur_row_d = oh_idx;
         end
      end

      case (phase_q)
         PH_SETUP: begin
            if (start) begin
               if (ships_left_q != 5'd0) begin
                  phase_d  = PH_PLAY;
                  shots_d  = 8'd0;
                  result_d = RES_NONE;
               end
            end else if (place) begin
               if (cur_cell == CELL_EMPTY && int'(ships_left_q) < MAX_SHIPS) begin
                  cells_d[2*cur_idx +: 2] = CELL_SHIP;
                  ships_left_d            = ships_left_q + 5'd1;
               end else if (cur_cell == CELL_SHIP) begin
                  cells_d[2*cur_idx +: 2] = CELL_EMPTY;
                  ships_left_d            = ships_left_q - 5'd1;
               end
            end
         end
         PH_PLAY: begin
            if (fire) begin
               if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
               case (cur_cell)
                  CELL_EMPTY: begin
                     cells_d[2*cur_idx +: 2] = CELL_MISS;
                     result_d                = RES_MISS;
                  end
                  CELL_SHIP: begin
                     cells_d[2*cur_idx +: 2] = CELL_HIT;
                     result_d                = RES_HIT;
                     ships_left_d            = ships_left_q - 5'd1;
                     if (ships_left_q == 5'd1) phase_d = PH_DONE;
                  end
                  default: result_d = RES_REPEAT;
               endcase
            end
         end
         PH_DONE: begin
            if (start) begin
               cells_d      = '0;
               ships_left_d = 5'd0;
               shots_d      = 8'd0;
               result_d     = RES_NONE;
               phase_d      = PH_SETUP;
            end
         end
         default: phase_d = PH_SETUP;
      endcase

      game_over_d = (phase_d == PH_DONE);
   end

   // State registers; reset clears the board and returns to setup immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cells_q      <= '0;
         cur_row_q    <= 4'd0;
         cur_col_q    <= 4'd0;
         phase_q      <= PH_SETUP;
         ships_left_q <= 5'd0;
         shots_q      <= 8'd0;
         result_q     <= RES_NONE;
         sel_err_q    <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         cells_q      <= cells_d;
         cur_row_q    <= cur_row_d;
         cur_col_q    <= cur_col_d;
         phase_q      <= phase_d;
         ships_left_q <= ships_left_d;
         shots_q      <= shots_d;
         result_q     <= result_d;
         sel_err_q    <= sel_err_d;
         game_over_q  <= game_over_d;
      end
   end

   // Display view: hide un-hit ships from the opponent unless reveal is set.
   always_comb begin
      cell_state = cells_q;
      for (int i = 0; i < CELLS; i++) begin
         if (phase_q != PH_SETUP && !reveal && cells_q[2*i +: 2] == CELL_SHIP)
            cell_state[2*i +: 2] = CELL_EMPTY;
      end
   end

   assign cur_row     = cur_row_q;
   assign cur_col     = cur_col_q;
   assign phase       = phase_q;
   assign ships_left  = ships_left_q;
   assign shots       = shots_q;
   assign last_result = result_q;
   assign sel_err     = sel_err_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_grid_board_ctrl.sv
// Directed bench for grid_board_ctrl: a 4x4 instance plays a full game and a
// reset-mid-game scenario, an 8x5 instance exercises range checks and bit placement.
module tb_grid_board_ctrl;
   import grid_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // 4x4 instance
   logic [3:0]  sw_a;
   logic        is_col_a, load_a, place_a, fire_a, start_a, reveal_a;
   logic [31:0] cells_a;
   logic [3:0]  row_a, col_a;
   logic [1:0]  phase_a, res_a;
   logic [4:0]  ships_a;
   logic [7:0]  shots_a;
   logic        err_a, over_a;

   // 8x5 instance
   logic [7:0]  sw_b;
   logic        is_col_b, load_b, place_b, fire_b, start_b, reveal_b;
   logic [79:0] cells_b;
   logic [3:0]  row_b, col_b;
   logic [1:0]  phase_b, res_b;
   logic [4:0]  ships_b;
   logic [7:0]  shots_b;
   logic        err_b, over_b;

   grid_board_ctrl #(.ROWS(4), .COLS(4), .MAX_SHIPS(4)) dut_a (
      .clk(clk), .reset(reset), .sw(sw_a), .sw_is_col(is_col_a), .sw_load(load_a),
      .place(place_a), .fire(fire_a), .start(start_a), .reveal(reveal_a),
      .cell_state(cells_a), .cur_row(row_a), .cur_col(col_a), .phase(phase_a),
      .ships_left(ships_a), .shots(shots_a), .last_result(res_a),
      .sel_err(err_a), .game_over(over_a)
   );

   grid_board_ctrl #(.ROWS(8), .COLS(5), .MAX_SHIPS(4)) dut_b (
      .clk(clk), .reset(reset), .sw(sw_b), .sw_is_col(is_col_b), .sw_load(load_b),
      .place(place_b), .fire(fire_b), .start(start_b), .reveal(reveal_b),
      .cell_state(cells_b), .cur_row(row_b), .cur_col(col_b), .phase(phase_b),
      .ships_left(ships_b), .shots(shots_b), .last_result(res_b),
      .sel_err(err_b), .game_over(over_b)
   );

   typedef enum int {
      S_ROW, S_COL, S_PHASE, S_SHIPS, S_SHOTS, S_RES, S_ERR, S_OVER, S_CELLS,
      S_B_ROW, S_B_COL, S_B_ERR, S_B_PHASE, S_B_CELLS
   } sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      logic [79:0] val;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] bm;

   function automatic logic [79:0] observe(input sel_e s);
      case (s)
         S_ROW:     return 80'(row_a);
         S_COL:     return 80'(col_a);
         S_PHASE:   return 80'(phase_a);
         S_SHIPS:   return 80'(ships_a);
         S_SHOTS:   return 80'(shots_a);
         S_RES:     return 80'(res_a);
         S_ERR:     return 80'(err_a);
         S_OVER:    return 80'(over_a);
         S_CELLS:   return 80'(cells_a);
         S_B_ROW:   return 80'(row_b);
         S_B_COL:   return 80'(col_b);
         S_B_ERR:   return 80'(err_b);
         S_B_PHASE: return 80'(phase_b);
         default:   return cells_b;
      endcase
   endfunction

   function automatic logic [31:0] setc(input logic [31:0] v, input int r, input int c,
                                        input logic [1:0] code);
      logic [31:0] t;
      t = v;
      t[2*(r*4+c) +: 2] = code;
      return t;
   endfunction

   // Opponent's view of the board: un-hit ships shown as empty.
   function automatic logic [31:0] masked(input logic [31:0] v);
      logic [31:0] t;
      t = v;
      for (int i = 0; i < 16; i++)
         if (t[2*i +: 2] == 2'd1) t[2*i +: 2] = 2'd0;
      return t;
   endfunction

   task automatic expectVal(input string tag, input sel_e s, input logic [79:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [79:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.val) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic applyStimulus(input logic [3:0] s, input logic c, input logic l,
                                input logic p, input logic f, input logic st);
      @(negedge clk);
      sw_a = s; is_col_a = c; load_a = l; place_a = p; fire_a = f; start_a = st;
      @(posedge clk);
      #1;
      load_a = 1'b0; place_a = 1'b0; fire_a = 1'b0; start_a = 1'b0;
   endtask

   task automatic applyStimulusB(input logic [7:0] s, input logic c, input logic l,
                                 input logic p, input logic f, input logic st);
      @(negedge clk);
      sw_b = s; is_col_b = c; load_b = l; place_b = p; fire_b = f; start_b = st;
      @(posedge clk);
      #1;
      load_b = 1'b0; place_b = 1'b0; fire_b = 1'b0; start_b = 1'b0;
   endtask

   task automatic moveA(input int r, input int c);
      applyStimulus(4'(1 << r), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'(1 << c), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic placeA();
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic fireA();
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic startA();
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic expectResetA(input string tag);
      expectVal({tag, "_cells"}, S_CELLS, 80'd0);
      expectVal({tag, "_row"},   S_ROW,   80'd0);
      expectVal({tag, "_col"},   S_COL,   80'd0);
      expectVal({tag, "_phase"}, S_PHASE, 80'(PH_SETUP));
      expectVal({tag, "_ships"}, S_SHIPS, 80'd0);
      expectVal({tag, "_shots"}, S_SHOTS, 80'd0);
      expectVal({tag, "_res"},   S_RES,   80'(RES_NONE));
      expectVal({tag, "_err"},   S_ERR,   80'd0);
      expectVal({tag, "_over"},  S_OVER,  80'd0);
   endtask

   initial begin
      logic [79:0] exp_b;
      reset = 1'b0;
      sw_a = '0; is_col_a = 0; load_a = 0; place_a = 0; fire_a = 0; start_a = 0; reveal_a = 0;
      sw_b = '0; is_col_b = 0; load_b = 0; place_b = 0; fire_b = 0; start_b = 0; reveal_b = 0;
      bm = '0;
      #1 reset = 1'b1;
      #11;
      expectResetA("rst");
      checkOutput();
      @(negedge clk);
      reset = 1'b0;

      // Cursor loads: non-one-hot rejected, valid column accepted.
      expectVal("bad_onehot_err", S_ERR, 80'd1);
      expectVal("bad_onehot_row", S_ROW, 80'd0);
      applyStimulus(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      expectVal("col_load_col", S_COL, 80'd2);
      expectVal("col_load_err", S_ERR, 80'd0);
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();

      // Fill the diagonal up to the ship limit.
      for (int i = 0; i < 4; i++) begin
         moveA(i, i);
         placeA();
         bm = setc(bm, i, i, 2'd1);
      end
      expectVal("place4_ships", S_SHIPS, 80'd4);
      expectVal("place4_cells", S_CELLS, 80'(bm));
      checkOutput();

      moveA(0, 1);
      expectVal("place5_ships", S_SHIPS, 80'd4);
      expectVal("place5_cells", S_CELLS, 80'(bm));
      placeA();
      checkOutput();

      moveA(0, 0);
      bm = setc(bm, 0, 0, 2'd0);
      expectVal("unplace_ships", S_SHIPS, 80'd3);
      expectVal("unplace_cells", S_CELLS, 80'(bm));
      placeA();
      checkOutput();

      for (int i = 1; i < 4; i++) begin
         moveA(i, i);
         placeA();
      end
      bm = '0;
      expectVal("empty_start_phase", S_PHASE, 80'(PH_SETUP));
      expectVal("empty_ships", S_SHIPS, 80'd0);
      startA();
      checkOutput();

      moveA(2, 1);
      bm = setc(bm, 2, 1, 2'd1);
      expectVal("setup_show_cells", S_CELLS, 80'(bm));
      expectVal("one_ship", S_SHIPS, 80'd1);
      placeA();
      checkOutput();

      expectVal("play_phase", S_PHASE, 80'(PH_PLAY));
      expectVal("play_shots", S_SHOTS, 80'd0);
      expectVal("play_res", S_RES, 80'(RES_NONE));
      expectVal("play_mask", S_CELLS, 80'(masked(bm)));
      startA();
      checkOutput();

      reveal_a = 1'b1;
      #1;
      expectVal("reveal_cells", S_CELLS, 80'(bm));
      checkOutput();
      reveal_a = 1'b0;

      // Miss, then a repeat shot on the same cell.
      moveA(0, 0);
      bm = setc(bm, 0, 0, 2'd3);
      expectVal("miss_res", S_RES, 80'(RES_MISS));
      expectVal("miss_shots", S_SHOTS, 80'd1);
      expectVal("miss_cells", S_CELLS, 80'(masked(bm)));
      fireA();
      checkOutput();
      expectVal("repeat_res", S_RES, 80'(RES_REPEAT));
      expectVal("repeat_shots", S_SHOTS, 80'd2);
      expectVal("repeat_cells", S_CELLS, 80'(masked(bm)));
      fireA();
      checkOutput();

      // Load and fire together: the shot lands on the old cursor (0,1).
      applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bm = setc(bm, 0, 1, 2'd3);
      expectVal("loadfire_res", S_RES, 80'(RES_MISS));
      expectVal("loadfire_shots", S_SHOTS, 80'd3);
      expectVal("loadfire_ships", S_SHIPS, 80'd1);
      expectVal("loadfire_row", S_ROW, 80'd2);
      expectVal("loadfire_cells", S_CELLS, 80'(masked(bm)));
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput();

      expectVal("play_place_ships", S_SHIPS, 80'd1);
      expectVal("play_place_cells", S_CELLS, 80'(masked(bm)));
      placeA();
      checkOutput();

      bm = setc(bm, 2, 1, 2'd2);
      expectVal("hit_res", S_RES, 80'(RES_HIT));
      expectVal("hit_ships", S_SHIPS, 80'd0);
      expectVal("hit_phase", S_PHASE, 80'(PH_DONE));
      expectVal("hit_over", S_OVER, 80'd1);
      expectVal("hit_shots", S_SHOTS, 80'd4);
      expectVal("hit_cells", S_CELLS, 80'(bm));
      fireA();
      checkOutput();

      expectVal("done_fire_shots", S_SHOTS, 80'd4);
      expectVal("done_fire_cells", S_CELLS, 80'(bm));
      fireA();
      checkOutput();

      bm = '0;
      expectVal("restart_cells", S_CELLS, 80'd0);
      expectVal("restart_phase", S_PHASE, 80'(PH_SETUP));
      expectVal("restart_ships", S_SHIPS, 80'd0);
      expectVal("restart_shots", S_SHOTS, 80'd0);
      expectVal("restart_res", S_RES, 80'(RES_NONE));
      expectVal("restart_over", S_OVER, 80'd0);
      startA();
      checkOutput();

      // Mid-game reset, asserted between clock edges.
      placeA();
      startA();
      moveA(3, 3);
      expectVal("mid_phase", S_PHASE, 80'(PH_PLAY));
      expectVal("mid_shots", S_SHOTS, 80'd1);
      fireA();
      checkOutput();
      expectVal("mid_err", S_ERR, 80'd1);
      applyStimulus(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      #2 reset = 1'b1;
      #1;
      expectResetA("midrst");
      checkOutput();
      @(negedge clk);
      reset = 1'b0;
      expectVal("post_rst_row", S_ROW, 80'd1);
      expectVal("post_rst_err", S_ERR, 80'd0);
      applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();

      // 8x5 board: column index 5 is out of range, row index 5 is fine.
      expectVal("b_col_err", S_B_ERR, 80'd1);
      expectVal("b_col_keep", S_B_COL, 80'd0);
      applyStimulusB(8'b0010_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      expectVal("b_row", S_B_ROW, 80'd5);
      expectVal("b_row_err", S_B_ERR, 80'd0);
      applyStimulusB(8'b0010_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();

      applyStimulusB(8'b0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulusB(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expectVal("b_phase", S_B_PHASE, 80'(PH_PLAY));
      applyStimulusB(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput();
      applyStimulusB(8'b1000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulusB(8'b0001_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_b = '0;
      exp_b[79:78] = 2'b11;
      expectVal("b_corner_row", S_B_ROW, 80'd7);
      expectVal("b_corner_col", S_B_COL, 80'd4);
      expectVal("b_corner_cells", S_B_CELLS, exp_b);
      applyStimulusB(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
